// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and channel encoding for the register-file writeback arbiter
// Contents: default data/address widths, register count helper, writeback channel select enum.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Number of architectural registers addressed by an aw-bit register index.
  function automatic int num_regs_for(input int aw);
    return 1 << aw;
  endfunction

  localparam int NUM_REGS = num_regs_for(DEF_ADDR_W);

  // Writeback requester: A is the ALU channel, B is the load channel.
  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-requester writeback queue
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, empties the queue
//   push      enqueue push_data (ignored when full unless popping in the same cycle)
//   push_data entry to enqueue
//   pop       dequeue the head (ignored when empty)
//   full      queue holds DEPTH entries
//   empty     queue holds no entries
//   head      oldest entry, valid while !empty
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full queue may still accept an entry when its head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through head while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-channel round-robin register-file writeback arbiter with pending scoreboard
// Ports:
//   elk                         rising-edge clock
//   nrst                        synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data  ALU writeback request channel
//   b_valid/b_ready/b_addr/b_data  load writeback request channel
//   iss_valid/iss_addr          destination register marked pending at issue
//   wr_en/wr_addr/wr_data       registered register-file write port
//   pending                     per-register outstanding-write bits (bit 0 always 0)
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              elk,
  input  logic                              nrst,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [ADDR_W-1:0]                 a_addr,
  input  logic [DATA_W-1:0]                 a_data,
  input  logic                              b_valid,
  output logic                              b_ready,
  input  logic [ADDR_W-1:0]                 b_addr,
  input  logic [DATA_W-1:0]                 b_data,
  input  logic                              iss_valid,
  input  logic [ADDR_W-1:0]                 iss_addr,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [DATA_W-1:0]                 wr_data,
  output logic [num_regs_for(ADDR_W)-1:0]   pending
);

  localparam int EW = ADDR_W + DATA_W;

  logic          a_full, a_empty, b_full, b_empty;
  logic [EW-1:0] a_head, b_head, win_head;
  logic          a_push, b_push, a_pop, b_pop;
  logic          grant_valid;
  ch_e           grant_ch;
  ch_e           last_grant;

  // Ready is a pure function of queue occupancy and reset, never of valid.
  assign a_ready = !nrst && !a_full;
  assign b_ready = !nrst && !b_full;

  // Writes to x0 complete the handshake but are dropped here.
  assign a_push = a_valid && a_ready && (a_addr != '0);
  assign b_push = b_valid && b_ready && (b_addr != '0);

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk       (elk),
    .rst       (nrst),
    .push      (a_push),
    .push_data ({a_addr, a_data}),
    .pop       (a_pop),
    .full      (a_full),
    .empty     (a_empty),
    .head      (a_head)
  );

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (elk),
    .rst       (nrst),
    .push      (b_push),
    .push_data ({b_addr, b_data}),
    .pop       (b_pop),
    .full      (b_full),
    .empty     (b_empty),
    .head      (b_head)
  );

  // Sole non-empty queue wins; on contention the channel not granted last wins.
  always_comb begin
    grant_valid = !a_empty || !b_empty;
    grant_ch    = CH_A;
    if (!a_empty && !b_empty) begin
      grant_ch = (last_grant == CH_A) ? CH_B : CH_A;
    end else if (!b_empty) begin
      grant_ch = CH_B;
    end
  end

  assign a_pop    = !nrst && grant_valid && (grant_ch == CH_A);
  assign b_pop    = !nrst && grant_valid && (grant_ch == CH_B);
  assign win_head = (grant_ch == CH_A) ? a_head : b_head;

  // Write port: the granted head is registered for exactly one cycle; address
  // and data hold their last value while idle.
  always_ff @(posedge elk) begin
    if (nrst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= CH_B;
    end else begin
      wr_en <= grant_valid;
      if (grant_valid) begin
        wr_addr    <= win_head[EW-1:DATA_W];
        wr_data    <= win_head[DATA_W-1:0];
        last_grant <= grant_ch;
      end
    end
  end

  // Scoreboard: the set is written after the clear so a same-edge issue to the
  // register being written back leaves it pending.
  always_ff @(posedge elk) begin
    if (nrst) begin
      pending <= '0;
    end else begin
      if (wr_en) pending[wr_addr] <= 1'b0;
      if (iss_valid && (iss_addr != '0)) pending[iss_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard testbench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int NR    = 32;

  logic          elk = 1'b0;
  logic          nrst;
  logic          a_valid, b_valid, iss_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, iss_addr;
  logic [DW-1:0] a_data, b_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model state
  ent_t          qa[$];
  ent_t          qb[$];
  ent_t          sb[$];
  bit            m_last_b = 1'b1;
  bit            m_wr_en = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  logic [NR-1:0] m_pend = '0;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .elk       (elk),
    .nrst      (nrst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (pending)
  );

  always #5 elk = ~elk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues of accepted writes, round-robin by rule.
  initial begin
    forever begin
      bit   ra, rb, ga, gb, pick_b;
      ent_t e;
      @(posedge elk);
      if (nrst) begin
        qa.delete();
        qb.delete();
        sb.delete();
        m_last_b  = 1'b1;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_pend    = '0;
      end else begin
        ra = qa.size() < DEPTH;
        rb = qb.size() < DEPTH;
        if (m_wr_en) m_pend[m_wr_addr] = 1'b0;
        if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        ga = qa.size() > 0;
        gb = qb.size() > 0;
        if (ga || gb) begin
          pick_b = gb && (!ga || !m_last_b);
          e = pick_b ? qb.pop_front() : qa.pop_front();
          m_wr_en   = 1'b1;
          m_wr_addr = e.addr;
          m_wr_data = e.data;
          m_last_b  = pick_b;
          sb.push_back(e);
        end else begin
          m_wr_en = 1'b0;
        end
        if (a_valid && ra && a_addr != 0) qa.push_back('{a_addr, a_data});
        if (b_valid && rb && b_addr != 0) qb.push_back('{b_addr, b_data});
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each DUT write.
  initial begin
    forever begin
      ent_t e;
      @(negedge elk);
      chk("a_ready", a_ready, (!nrst && qa.size() < DEPTH));
      chk("b_ready", b_ready, (!nrst && qb.size() < DEPTH));
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_addr_hold", wr_addr, m_wr_addr);
      chk("wr_data_hold", wr_data, m_wr_data);
      chk("pending", pending, m_pend);
      if (wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got wr_en=1 addr 0x%0h expected no write at %0t", wr_addr, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_addr", wr_addr, e.addr);
          chk("sb_data", wr_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge elk);
    #1;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    nrst = 1'b1;
    idle();
    repeat (n) step();
    nrst = 1'b0;
  endtask

  // Both channels offer a stream, each holding its request until accepted.
  task automatic stream_both(input int cycles, input logic [DW-1:0] tag, output bit saw_a_stall);
    int ia = 0;
    int ib = 0;
    saw_a_stall = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      bit acc_a, acc_b;
      a_valid = 1'b1;
      a_addr  = AW'(8 + (ia % 8));
      a_data  = tag + DW'(ia);
      b_valid = 1'b1;
      b_addr  = AW'(16 + (ib % 8));
      b_data  = tag + 32'h100 + DW'(ib);
      acc_a = a_ready;
      acc_b = b_ready;
      if (!a_ready) saw_a_stall = 1'b1;
      step();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    idle();
  endtask

  initial begin
    bit stall;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; iss_addr = '0;
    do_reset(2);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_pending", pending, 0);

    // Single write to r3 with r3 pending
    iss_valid = 1'b1; iss_addr = 5'd3;
    step();
    iss_valid = 1'b0;
    chk("iss_r3_set", pending[3], 1);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    chk("single_wr_not_yet", wr_en, 0);
    step();
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 3);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    step();
    chk("single_pend_clr", pending[3], 0);
    repeat (2) step();

    // Contention from reset: A first, then B
    do_reset(1);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
    step();
    idle();
    step();
    chk("cont_first_en", wr_en, 1);
    chk("cont_first_addr", wr_addr, 5);
    step();
    chk("cont_second_en", wr_en, 1);
    chk("cont_second_addr", wr_addr, 6);
    chk("cont_second_data", wr_data, 32'h22);
    repeat (3) step();

    // Backpressure: both streaming fills the A queue
    stream_both(12, 32'hA000, stall);
    chk("a_stall_seen", stall, 1);
    repeat (8) step();

    // Write to x0 is accepted and discarded
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    chk("x0_b_ready", b_ready, 1);
    step();
    idle();
    repeat (4) step();

    // Scoreboard race on r7
    iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    step();
    a_valid = 1'b0;
    step();
    chk("race_wr_en", wr_en, 1);
    chk("race_wr_addr", wr_addr, 7);
    iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("race_pend7", pending[7], 1);
    repeat (2) step();

    // Reset mid-flight
    iss_valid = 1'b1; iss_addr = 5'd9;
    stream_both(4, 32'hC000, stall);
    nrst = 1'b1;
    step();
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", {a_ready, b_ready}, 2'b00);
    nrst = 1'b0;
    step();
    chk("midrst_wr_en_after", wr_en, 0);
    chk("midrst_ready_after", {a_ready, b_ready}, 2'b11);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a_valid   = 1'($urandom_range(0, 1));
      a_addr    = AW'($urandom);
      a_data    = $urandom;
      b_valid   = 1'($urandom_range(0, 1));
      b_addr    = AW'($urandom);
      b_data    = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = AW'($urandom);
      nrst      = ($urandom_range(0, 199) == 0);
      step();
    end
    nrst = 1'b0;
    idle();
    repeat (10) step();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
